hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core. It produces the stall and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It works alongside the EX-stage forwarding unit and covers the hazards forwarding cannot resolve: load-use, taken branch/jump redirect, multi-cycle data-memory wait, and instruction-fetch wait/discard. It tracks outstanding memory waits and in-flight fetches with a small state machine, a pending flag and a watchdog counter.

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for the 5-stage pipeline (load-use, redirect,
// data-memory wait, fetch wait/discard). Optional counters: define HAZARD_CTRL_PERF_EN.
`default_nettype none

module hazard_ctrl #(
    parameter int DWAIT_MAX = 255,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_Rs1,
    input  logic [4:0]        id_Rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        ex_Rd,
    input  logic              ex_MemRead,
    input  logic              ex_redirect,
    input  logic              mem_req,
    input  logic              dmem_ready,
    input  logic              imem_ready,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              id_ex_stall,
    output logic              ex_mem_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              mem_wb_flush,
    output logic              mem_timeout,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flush_events
);

    localparam int CW = $clog2(DWAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DWAIT_MAX);
    localparam logic [CW-1:0] CNT_TMO = CW'(DWAIT_MAX - 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DWAIT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic dstall, load_use, fbub;

    assign dstall   = mem_req & ~dmem_ready;
    assign load_use = ex_MemRead & (ex_Rd != 5'd0) &
                      ((id_use_rs1 & (ex_Rd == id_Rs1)) | (id_use_rs2 & (ex_Rd == id_Rs2)));
    assign fbub     = ~imem_ready | drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (dstall) state_d = ST_DWAIT;
            ST_DWAIT: if (dmem_ready) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // cnt_q holds the number of wait cycles already completed in the current freeze
    always_comb begin
        cnt_d = '0;
        if (dstall) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // A redirect with a fetch still outstanding marks that fetch for discard
    always_comb begin
        drop_d = drop_q;
        if (imem_ready) drop_d = 1'b0;
        if (ex_redirect & ~imem_ready) drop_d = 1'b1;
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        mem_timeout  = 1'b0;
        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (dstall) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
            mem_timeout  = (cnt_q == CNT_TMO);
        end else if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (fbub) begin
            pc_stall     = 1'b1;
            if_id_flush  = 1'b1;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (pc_stall) perf_stall_q <= perf_stall_q + 1'b1;
            if (ex_redirect & ~dstall) perf_flush_q <= perf_flush_q + 1'b1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_events = perf_flush_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_flush_events = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + random stimulus against a behavioural model of the hazard rules.
`default_nettype none

module tb_hazard_ctrl;

    localparam int DWAIT_MAX = 3;
    localparam int PERF_W    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_use_rs1, id_use_rs2, ex_MemRead, ex_redirect;
    logic       mem_req, dmem_ready, imem_ready;
    logic [4:0] id_Rs1, id_Rs2, ex_Rd;
    logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic       if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout;
    logic [PERF_W-1:0] perf_stall_cycles, perf_flush_events;

    hazard_ctrl #(.DWAIT_MAX(DWAIT_MAX), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst),
        .id_Rs1(id_Rs1), .id_Rs2(id_Rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_Rd(ex_Rd), .ex_MemRead(ex_MemRead), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush), .mem_timeout(mem_timeout),
        .perf_stall_cycles(perf_stall_cycles), .perf_flush_events(perf_flush_events)
    );

    int checks   = 0;
    int failures = 0;

    // model state: consecutive prior wait cycles, discard flag, event tallies
    int m_run  = 0;
    bit m_drop = 1'b0;
    int m_pstall = 0;
    int m_pflush = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output vector order: pc, if_id, id_ex, ex_mem stalls; if_id, id_ex, mem_wb flushes; timeout
    task automatic step(input string tag, input bit r, input int rs1, input int rs2,
                        input bit u1, input bit u2, input int rd, input bit mr,
                        input bit redir, input bit mreq, input bit dready, input bit iready);
        bit dst, lu, fb, tmo;
        logic [7:0] exp, got;
        int exp_ps, exp_pf;
        @(negedge clk);
        rst = r; id_Rs1 = 5'(rs1); id_Rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
        ex_Rd = 5'(rd); ex_MemRead = mr; ex_redirect = redir;
        mem_req = mreq; dmem_ready = dready; imem_ready = iready;
        #1;
        dst = mreq && !dready;
        lu  = mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
        fb  = !iready || m_drop;
        tmo = dst && (m_run + 1 == DWAIT_MAX);
        if (r)          exp = 8'b0000_1110;
        else if (dst)   exp = {4'b1111, 3'b001, tmo};
        else if (redir) exp = 8'b0000_1100;
        else if (lu)    exp = 8'b1100_0100;
        else if (fb)    exp = 8'b1000_1000;
        else            exp = 8'b0;
        got = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout};
        check(tag, {24'd0, got}, {24'd0, exp});
`ifdef HAZARD_CTRL_PERF_EN
        exp_ps = m_pstall % (1 << PERF_W);
        exp_pf = m_pflush % (1 << PERF_W);
`else
        exp_ps = 0;
        exp_pf = 0;
`endif
        check({tag, "_perf_stall"}, {24'd0, perf_stall_cycles}, exp_ps);
        check({tag, "_perf_flush"}, {24'd0, perf_flush_events}, exp_pf);
        if (r) begin
            m_run = 0; m_drop = 1'b0; m_pstall = 0; m_pflush = 0;
        end else begin
            m_run = dst ? m_run + 1 : 0;
            if (redir && !iready) m_drop = 1'b1;
            else if (iready)      m_drop = 1'b0;
            m_pstall += exp[7];
            if (redir && !dst) m_pflush++;
        end
        @(posedge clk);
    endtask

    // quiet cycle: no hazards, fetch ready
    task automatic idle(input string tag);
        step(tag, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    initial begin
        bit mreq_r;
        step("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("reset1", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        idle("idle");

        step("load_use", 0, 5, 7, 1, 0, 5, 1, 0, 0, 1, 1);
        step("load_use_after", 0, 5, 7, 1, 0, 5, 0, 0, 0, 1, 1);
        step("load_use_x0", 0, 0, 7, 1, 0, 0, 1, 0, 0, 1, 1);
        step("load_use_rs2", 0, 3, 9, 0, 1, 9, 1, 0, 0, 1, 1);

        for (int i = 0; i < 4; i++) step("dwait", 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1);
        step("dwait_release", 0, 1, 2, 0, 0, 0, 0, 0, 1, 1, 1);
        idle("idle2");

        for (int i = 0; i < 6; i++) step("timeout", 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1);
        step("timeout_release", 0, 1, 2, 0, 0, 0, 0, 0, 1, 1, 1);

        step("redir_inflight", 0, 1, 2, 0, 0, 0, 0, 1, 0, 1, 0);
        step("drop_wait1", 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0);
        step("drop_wait2", 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0);
        step("drop_discard", 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1);
        idle("clean_fetch");

        step("redir_vs_lu", 0, 5, 7, 1, 0, 5, 1, 1, 0, 1, 1);
        step("freeze_vs_redir", 0, 1, 2, 0, 0, 0, 0, 1, 1, 0, 0);
        step("freeze_release_redir", 0, 1, 2, 0, 0, 0, 0, 1, 1, 1, 1);

        step("rst_dwait_a", 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1);
        step("rst_dwait_b", 0, 1, 2, 0, 0, 0, 0, 1, 1, 0, 0);
        step("rst_mid", 1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step("post_rst_wait", 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1);
        step("post_rst_release", 0, 1, 2, 0, 0, 0, 0, 0, 1, 1, 1);

        mreq_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 3) mreq_r = ~mreq_r;
            step("rand", $urandom_range(0, 99) == 0,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 3), $urandom_range(0, 1),
                 $urandom_range(0, 9) < 2, mreq_r,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
